// File: rtl/guess_entry_if.sv
// Guess-entry bus: pushbuttons, peg colour and controller handshake in; packed guess out.
//   master : drives btn_enter, btn_clear, peg_sel, next_guess; observes the outputs
//   slave  : guess_entry itself; drives guess_d, guess_en, peg_count, locked
interface guess_entry_if #(
  parameter int unsigned PEG_W    = 2,
  parameter int unsigned NUM_PEGS = 4
);
  localparam int unsigned GUESS_W = PEG_W * NUM_PEGS;
  localparam int unsigned CNT_W   = $clog2(NUM_PEGS + 1);

  logic               btn_enter;
  logic               btn_clear;
  logic [PEG_W-1:0]   peg_sel;
  logic               next_guess;
  logic [GUESS_W-1:0] guess_d;
  logic               guess_en;
  logic [CNT_W-1:0]   peg_count;
  logic               locked;

  modport master (
    output btn_enter, btn_clear, peg_sel, next_guess,
    input  guess_d, guess_en, peg_count, locked
  );

  modport slave (
    input  btn_enter, btn_clear, peg_sel, next_guess,
    output guess_d, guess_en, peg_count, locked
  );
endinterface

// File: rtl/guess_entry.sv
// Collects NUM_PEGS colour pegs from debounced enter presses, then presents the
// packed guess with a one-cycle load pulse and locks until next_guess.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : guess_entry_if slave (buttons, peg_sel, next_guess in; guess_d,
//           guess_en, peg_count, locked out)
module guess_entry #(
  parameter int unsigned PEG_W    = 2,
  parameter int unsigned NUM_PEGS = 4
) (
  input  logic          clk,
  input  logic          reset,
  guess_entry_if.slave  bus
);
  localparam int unsigned GUESS_W = PEG_W * NUM_PEGS;
  localparam int unsigned CNT_W   = $clog2(NUM_PEGS + 1);

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_COMMIT = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  state_e             state, state_nxt;
  logic [2:0]         enter_sync, clear_sync;
  logic               enter_p, clear_p;
  logic [GUESS_W-1:0] buffer;
  logic [CNT_W-1:0]   count;
  logic               buf_clr, buf_shift;
  logic               guess_en_c, locked_c;

  // Two-flop synchroniser plus history flop per button; bit0=s1, bit1=s2, bit2=s3
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enter_sync <= 3'b000;
      clear_sync <= 3'b000;
    end else begin
      enter_sync <= {enter_sync[1:0], bus.btn_enter};
      clear_sync <= {clear_sync[1:0], bus.btn_clear};
    end
  end

  assign enter_p = enter_sync[1] & ~enter_sync[2];
  assign clear_p = clear_sync[1] & ~clear_sync[2];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_ENTRY;
    else        state <= state_nxt;
  end

  // Next state and datapath controls; pulses outside ENTRY are simply dropped
  always_comb begin
    state_nxt = state;
    buf_clr   = 1'b0;
    buf_shift = 1'b0;
    unique case (state)
      ST_ENTRY: begin
        if (clear_p) begin
          buf_clr = 1'b1;
        end else if (enter_p) begin
          buf_shift = 1'b1;
          if (count == CNT_W'(NUM_PEGS - 1)) state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.next_guess) begin
          buf_clr   = 1'b1;
          state_nxt = ST_ENTRY;
        end
      end
      default: state_nxt = ST_ENTRY;
    endcase
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    guess_en_c = 1'b0;
    locked_c   = 1'b0;
    unique case (state)
      ST_COMMIT: begin
        guess_en_c = 1'b1;
        locked_c   = 1'b1;
      end
      ST_WAIT:  locked_c = 1'b1;
      default: ;
    endcase
  end

  // Peg shift buffer and counter; first peg ends up in the top slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer <= '0;
      count  <= '0;
    end else if (buf_clr) begin
      buffer <= '0;
      count  <= '0;
    end else if (buf_shift) begin
      buffer <= {buffer[GUESS_W-PEG_W-1:0], bus.peg_sel};
      count  <= count + CNT_W'(1);
    end
  end

  assign bus.guess_d   = buffer;
  assign bus.peg_count = count;
  assign bus.guess_en  = guess_en_c;
  assign bus.locked    = locked_c;
endmodule
